// File: rtl/neopixel_rx.sv
// rtl/neopixel_rx.sv - WS2812-style one-wire receiver assembling GRB pixel words onto a valid/ready stream
// Optional NEOPIXEL_RX_STATS_EN adds frame_count/err_count outputs.
module neopixel_rx #(
  parameter int MIN_HIGH_CYC   = 5,
  parameter int BIT_THRESH_CYC = 30,
  parameter int MAX_HIGH_CYC   = 60,
  parameter int LATCH_CYC      = 2500,
  parameter int PIXEL_BITS     = 24,
  parameter int IDX_W          = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  one_wire,
  output logic [PIXEL_BITS-1:0] pixel_data,
  output logic [IDX_W-1:0]      pixel_index,
  output logic                  pixel_valid,
  input  logic                  pixel_ready,
  output logic                  frame_end,
  output logic                  pulse_err,
  output logic                  partial_err,
  output logic                  overrun,
  input  logic                  clear_err
`ifdef NEOPIXEL_RX_STATS_EN
  ,
  output logic [15:0]           frame_count,
  output logic [15:0]           err_count
`endif
);

  localparam int LOW_W  = $clog2(LATCH_CYC + 1);
  localparam int HIGH_W = $clog2(MAX_HIGH_CYC + 2);
  localparam int BCNT_W = $clog2(PIXEL_BITS + 1);

  localparam logic [LOW_W-1:0]  LATCH_V   = LOW_W'(LATCH_CYC);
  localparam logic [LOW_W-1:0]  LATCH_M1  = LOW_W'(LATCH_CYC - 1);
  localparam logic [LOW_W-1:0]  LOW_ONE   = LOW_W'(1);
  localparam logic [HIGH_W-1:0] MIN_V     = HIGH_W'(MIN_HIGH_CYC);
  localparam logic [HIGH_W-1:0] THR_V     = HIGH_W'(BIT_THRESH_CYC);
  localparam logic [HIGH_W-1:0] MAX_V     = HIGH_W'(MAX_HIGH_CYC);
  localparam logic [HIGH_W-1:0] HSAT_V    = HIGH_W'(MAX_HIGH_CYC + 1);
  localparam logic [HIGH_W-1:0] HIGH_ONE  = HIGH_W'(1);
  localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(PIXEL_BITS - 1);
  localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_IDLE = 2'd1,
    S_LOW  = 2'd2,
    S_HIGH = 2'd3
  } state_t;

  state_t                state_q, state_d;
  state_t                ret_q, ret_d;
  logic                  sync1_q, sync2_q, prev_q;
  logic [LOW_W-1:0]      low_cnt_q, low_cnt_d;
  logic [HIGH_W-1:0]     high_cnt_q, high_cnt_d;
  logic [PIXEL_BITS-1:0] shift_q, shift_d;
  logic [BCNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]      idx_cnt_q, idx_cnt_d;
  logic [PIXEL_BITS-1:0] pixel_data_q, pixel_data_d;
  logic [IDX_W-1:0]      pixel_index_q, pixel_index_d;
  logic                  pixel_valid_q, pixel_valid_d;
  logic                  frame_end_q, frame_end_d;
  logic                  pulse_err_q, pulse_err_d;
  logic                  partial_err_q, partial_err_d;
  logic                  overrun_q, overrun_d;

  logic line, rise, fall;
  logic bit_ok, bit_val;
  logic pulse_set, partial_set, overrun_set;

  assign line = sync2_q;
  assign rise = sync2_q & ~prev_q;
  assign fall = ~sync2_q & prev_q;

  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    low_cnt_d     = low_cnt_q;
    high_cnt_d    = high_cnt_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    idx_cnt_d     = idx_cnt_q;
    pixel_data_d  = pixel_data_q;
    pixel_index_d = pixel_index_q;
    pixel_valid_d = pixel_valid_q & ~pixel_ready;
    frame_end_d   = 1'b0;
    bit_ok        = 1'b0;
    bit_val       = 1'b0;
    pulse_set     = 1'b0;
    partial_set   = 1'b0;
    overrun_set   = 1'b0;

    case (state_q)
      S_SYNC: begin
        // Only a full latch gap proves we are between frames.
        if (line) begin
          low_cnt_d = '0;
        end else if (low_cnt_q >= LATCH_M1) begin
          low_cnt_d = LATCH_V;
          state_d   = S_IDLE;
        end else begin
          low_cnt_d = low_cnt_q + LOW_ONE;
        end
      end

      S_IDLE, S_LOW: begin
        if (rise) begin
          state_d    = S_HIGH;
          ret_d      = state_q;
          high_cnt_d = HIGH_ONE;
        end else if (!line && low_cnt_q != LATCH_V) begin
          low_cnt_d = low_cnt_q + LOW_ONE;
          if (low_cnt_q == LATCH_M1) begin
            frame_end_d = 1'b1;
            idx_cnt_d   = '0;
            bit_cnt_d   = '0;
            partial_set = (bit_cnt_q != '0);
            state_d     = S_IDLE;
          end
        end
      end

      S_HIGH: begin
        if (fall) begin
          if (high_cnt_q < MIN_V) begin
            // Glitch: resume the interrupted low phase without restarting its count.
            state_d = ret_q;
          end else if (high_cnt_q > MAX_V) begin
            pulse_set = 1'b1;
            bit_cnt_d = '0;
            idx_cnt_d = '0;
            low_cnt_d = LOW_ONE;
            state_d   = S_SYNC;
          end else begin
            bit_ok    = 1'b1;
            bit_val   = (high_cnt_q > THR_V);
            low_cnt_d = LOW_ONE;
            state_d   = S_LOW;
          end
        end else if (high_cnt_q != HSAT_V) begin
          high_cnt_d = high_cnt_q + HIGH_ONE;
        end
      end

      default: state_d = S_SYNC;
    endcase

    if (bit_ok) begin
      shift_d = {shift_q[PIXEL_BITS-2:0], bit_val};
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d = '0;
        if (!pixel_valid_q || pixel_ready) begin
          pixel_data_d  = shift_d;
          pixel_index_d = idx_cnt_q;
          pixel_valid_d = 1'b1;
        end else begin
          overrun_set = 1'b1;
        end
        if (idx_cnt_q != '1) begin
          idx_cnt_d = idx_cnt_q + IDX_ONE;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + BCNT_ONE;
      end
    end

    // Set events take priority over a coincident clear.
    pulse_err_d   = pulse_set   | (pulse_err_q   & ~clear_err);
    partial_err_d = partial_set | (partial_err_q & ~clear_err);
    overrun_d     = overrun_set | (overrun_q     & ~clear_err);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      prev_q        <= 1'b0;
      state_q       <= S_SYNC;
      ret_q         <= S_IDLE;
      low_cnt_q     <= '0;
      high_cnt_q    <= '0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      idx_cnt_q     <= '0;
      pixel_data_q  <= '0;
      pixel_index_q <= '0;
      pixel_valid_q <= 1'b0;
      frame_end_q   <= 1'b0;
      pulse_err_q   <= 1'b0;
      partial_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      sync1_q       <= one_wire;
      sync2_q       <= sync1_q;
      prev_q        <= sync2_q;
      state_q       <= state_d;
      ret_q         <= ret_d;
      low_cnt_q     <= low_cnt_d;
      high_cnt_q    <= high_cnt_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      idx_cnt_q     <= idx_cnt_d;
      pixel_data_q  <= pixel_data_d;
      pixel_index_q <= pixel_index_d;
      pixel_valid_q <= pixel_valid_d;
      frame_end_q   <= frame_end_d;
      pulse_err_q   <= pulse_err_d;
      partial_err_q <= partial_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign pixel_data  = pixel_data_q;
  assign pixel_index = pixel_index_q;
  assign pixel_valid = pixel_valid_q;
  assign frame_end   = frame_end_q;
  assign pulse_err   = pulse_err_q;
  assign partial_err = partial_err_q;
  assign overrun     = overrun_q;

`ifdef NEOPIXEL_RX_STATS_EN
  logic [15:0] frame_count_q, frame_count_d;
  logic [15:0] err_count_q, err_count_d;

  always_comb begin
    frame_count_d = frame_count_q + {15'd0, frame_end_d};
    err_count_d   = err_count_q;
    if (clear_err) begin
      err_count_d = '0;
    end
    if ((pulse_set || partial_set) && err_count_d != 16'hFFFF) begin
      err_count_d = err_count_d + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
    end
  end

  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;
`endif

endmodule

// File: tb/tb_neopixel_rx.sv
// tb/tb_neopixel_rx.sv - directed self-checking bench for neopixel_rx
module tb_neopixel_rx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        one_wire = 1'b0;
  logic [23:0] pixel_data;
  logic [7:0]  pixel_index;
  logic        pixel_valid;
  logic        pixel_ready = 1'b1;
  logic        frame_end;
  logic        pulse_err;
  logic        partial_err;
  logic        overrun;
  logic        clear_err = 1'b0;
`ifdef NEOPIXEL_RX_STATS_EN
  logic [15:0] frame_count;
  logic [15:0] err_count;
`endif

  int vec = 0;
  int errs = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  int valid_cycles = 0;
  logic [23:0] rx_data_q[$];
  logic [7:0]  rx_idx_q[$];
  int          fe_q[$];

  neopixel_rx dut (
    .clk(clk), .reset_n(reset_n), .one_wire(one_wire),
    .pixel_data(pixel_data), .pixel_index(pixel_index), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .frame_end(frame_end), .pulse_err(pulse_err),
    .partial_err(partial_err), .overrun(overrun), .clear_err(clear_err)
`ifdef NEOPIXEL_RX_STATS_EN
    , .frame_count(frame_count), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (pixel_valid) valid_cycles++;
    if (pixel_valid && pixel_ready) begin
      rx_data_q.push_back(pixel_data);
      rx_idx_q.push_back(pixel_index);
    end
    if (frame_end) fe_q.push_back(cyc);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_capture();
    rx_data_q.delete();
    rx_idx_q.delete();
    fe_q.delete();
    valid_cycles = 0;
  endtask

  task automatic send_bit(input logic b);
    one_wire = 1'b1;
    tick(b ? 40 : 18);
    one_wire = 1'b0;
    last_fall_cyc = cyc;
    tick(b ? 22 : 44);
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(3);
    vec++; if (pixel_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b exp 0", pixel_valid); end
    vec++; if (pixel_data !== 24'h0) begin errs++; $display("FAIL reset_data got %h exp 000000", pixel_data); end
    vec++; if (pixel_index !== 8'h0) begin errs++; $display("FAIL reset_index got %h exp 00", pixel_index); end
    vec++; if ({frame_end, pulse_err, partial_err, overrun} !== 4'b0) begin
      errs++; $display("FAIL reset_flags got %b exp 0000", {frame_end, pulse_err, partial_err, overrun});
    end
`ifdef NEOPIXEL_RX_STATS_EN
    vec++; if ({frame_count, err_count} !== 32'h0) begin errs++; $display("FAIL reset_stats got %h exp 0", {frame_count, err_count}); end
`endif
    reset_n = 1'b1;
    tick(2510);
  endtask

  task automatic test_single_pixel();
    clear_capture();
    pixel_ready = 1'b1;
    send_word(24'hA5C33C);
    tick(5);
    vec++; if (rx_data_q.size() !== 1) begin errs++; $display("FAIL single_count got %0d exp 1", rx_data_q.size()); end
    if (rx_data_q.size() > 0) begin
      vec++; if (rx_data_q[0] !== 24'hA5C33C) begin errs++; $display("FAIL single_data got %h exp a5c33c", rx_data_q[0]); end
      vec++; if (rx_idx_q[0] !== 8'd0) begin errs++; $display("FAIL single_index got %0d exp 0", rx_idx_q[0]); end
    end
    vec++; if (valid_cycles !== 1) begin errs++; $display("FAIL single_valid_cycles got %0d exp 1", valid_cycles); end
    tick(2600);
  endtask

  task automatic test_frame();
    int fall_ref;
    clear_capture();
    send_word(24'h000001);
    send_word(24'hFFFFFF);
    fall_ref = last_fall_cyc;
    tick(2600);
    vec++; if (rx_data_q.size() !== 2) begin errs++; $display("FAIL frame_count got %0d exp 2", rx_data_q.size()); end
    if (rx_data_q.size() == 2) begin
      vec++; if (rx_data_q[0] !== 24'h000001 || rx_idx_q[0] !== 8'd0) begin
        errs++; $display("FAIL frame_pix0 got %h/%0d exp 000001/0", rx_data_q[0], rx_idx_q[0]);
      end
      vec++; if (rx_data_q[1] !== 24'hFFFFFF || rx_idx_q[1] !== 8'd1) begin
        errs++; $display("FAIL frame_pix1 got %h/%0d exp ffffff/1", rx_data_q[1], rx_idx_q[1]);
      end
    end
    vec++; if (fe_q.size() !== 1) begin errs++; $display("FAIL frame_end_pulses got %0d exp 1", fe_q.size()); end
    if (fe_q.size() > 0) begin
      vec++; if (fe_q[0] !== fall_ref + 2502) begin
        errs++; $display("FAIL frame_end_time got %0d exp %0d", fe_q[0] - fall_ref, 2502);
      end
    end
    clear_capture();
    send_word(24'h123456);
    tick(5);
    vec++; if (rx_data_q.size() !== 1 || (rx_data_q.size() > 0 && (rx_data_q[0] !== 24'h123456 || rx_idx_q[0] !== 8'd0))) begin
      errs++; $display("FAIL frame_restart got n=%0d %h exp 123456 idx 0", rx_data_q.size(), pixel_data);
    end
    tick(2600);
  endtask

  task automatic test_glitch();
    logic [23:0] w;
    clear_capture();
    w = 24'h5A5A5A;
    for (int i = 23; i >= 0; i--) begin
      if (i == 11) begin
        one_wire = 1'b1; tick(w[i] ? 40 : 18);
        one_wire = 1'b0; tick(10);
        one_wire = 1'b1; tick(3);
        one_wire = 1'b0; tick(w[i] ? 9 : 31);
      end else begin
        send_bit(w[i]);
      end
    end
    tick(5);
    vec++; if (rx_data_q.size() !== 1 || (rx_data_q.size() > 0 && rx_data_q[0] !== 24'h5A5A5A)) begin
      errs++; $display("FAIL glitch_data got n=%0d %h exp 5a5a5a", rx_data_q.size(), pixel_data);
    end
    vec++; if ({pulse_err, partial_err, overrun} !== 3'b0) begin
      errs++; $display("FAIL glitch_flags got %b exp 000", {pulse_err, partial_err, overrun});
    end
    tick(2600);
  endtask

  task automatic test_pulse_err();
    clear_capture();
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    one_wire = 1'b1; tick(70);
    one_wire = 1'b0; tick(5);
    vec++; if (pulse_err !== 1'b1) begin errs++; $display("FAIL pulse_err_set got %b exp 1", pulse_err); end
    tick(2600);
    vec++; if (rx_data_q.size() !== 0 || fe_q.size() !== 0) begin
      errs++; $display("FAIL pulse_err_quiet got px=%0d fe=%0d exp 0/0", rx_data_q.size(), fe_q.size());
    end
    send_word(24'h0F0F0F);
    tick(5);
    vec++; if (rx_data_q.size() !== 1 || (rx_data_q.size() > 0 && (rx_data_q[0] !== 24'h0F0F0F || rx_idx_q[0] !== 8'd0))) begin
      errs++; $display("FAIL pulse_err_recover got n=%0d %h exp 0f0f0f idx 0", rx_data_q.size(), pixel_data);
    end
    tick(2600);
    clear_err = 1'b1; tick(1); clear_err = 1'b0; tick(1);
    vec++; if (pulse_err !== 1'b0) begin errs++; $display("FAIL pulse_err_clear got %b exp 0", pulse_err); end
  endtask

  task automatic test_overrun();
    clear_capture();
    pixel_ready = 1'b0;
    send_word(24'h111111);
    vec++; if (pixel_valid !== 1'b1 || pixel_data !== 24'h111111) begin
      errs++; $display("FAIL overrun_first got v=%b %h exp 1 111111", pixel_valid, pixel_data);
    end
    send_word(24'h222222);
    tick(2);
    vec++; if (pixel_data !== 24'h111111 || pixel_index !== 8'd0) begin
      errs++; $display("FAIL overrun_hold got %h/%0d exp 111111/0", pixel_data, pixel_index);
    end
    vec++; if (overrun !== 1'b1) begin errs++; $display("FAIL overrun_flag got %b exp 1", overrun); end
    pixel_ready = 1'b1;
    tick(3);
    vec++; if (rx_data_q.size() !== 1 || pixel_valid !== 1'b0) begin
      errs++; $display("FAIL overrun_drain got n=%0d v=%b exp 1 0", rx_data_q.size(), pixel_valid);
    end
    tick(2600);
    clear_err = 1'b1; tick(1); clear_err = 1'b0; tick(1);
    vec++; if (overrun !== 1'b0) begin errs++; $display("FAIL overrun_clear got %b exp 0", overrun); end
  endtask

  task automatic test_partial();
`ifdef NEOPIXEL_RX_STATS_EN
    logic [15:0] fc0;
    fc0 = frame_count;
    vec++; if (err_count !== 16'd0) begin errs++; $display("FAIL stats_err_cleared got %0d exp 0", err_count); end
`endif
    clear_capture();
    for (int i = 0; i < 10; i++) send_bit(i[1]);
    tick(2600);
    vec++; if (partial_err !== 1'b1) begin errs++; $display("FAIL partial_flag got %b exp 1", partial_err); end
    vec++; if (valid_cycles !== 0) begin errs++; $display("FAIL partial_no_valid got %0d exp 0", valid_cycles); end
    vec++; if (fe_q.size() !== 1) begin errs++; $display("FAIL partial_frame_end got %0d exp 1", fe_q.size()); end
`ifdef NEOPIXEL_RX_STATS_EN
    vec++; if (frame_count !== fc0 + 16'd1) begin errs++; $display("FAIL stats_frames got %0d exp %0d", frame_count, fc0 + 16'd1); end
    vec++; if (err_count !== 16'd1) begin errs++; $display("FAIL stats_errs got %0d exp 1", err_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_frame();
    test_glitch();
    test_pulse_err();
    test_overrun();
    test_partial();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
